lfsr_gen: RTL and testbench
===========================

Name: lfsr_gen

Overview:
Parametrised linear feedback shift register and pseudo-random source, generalising the team's fixed 4-bit LFSR.
- Configurable width, tap polynomial, reset seed and feedback structure (Fibonacci or Galois).
- Adds run-time seed load, step enable, zero-seed protection and lockup detection.
- Serves as the common PRBS/scrambler/test-pattern source for datapath benches and BIST logic.

Parameters:
WIDTH, 8, register width in bits; legal range 3..32.
TAPS, 8'hB8, tap mask; bit i set means state[i] takes part in feedback; TAPS[WIDTH-1] must be 1.
SEED, 8'h01, reset and fallback seed; must be non-zero.
MODE, 0, 0 = Fibonacci (external XOR), 1 = Galois (internal XOR).

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  advance the LFSR one step this cycle
load  in  1  load seed_in this cycle
seed_in  in  WIDTH  run-time seed
out  out  WIDTH  current register state
bit_out  out  1  serial output, equal to out[WIDTH-1]
lockup  out  1  high while state is all-zero
seed_err  out  1  one-cycle pulse: zero seed rejected on load

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values: state = SEED, lockup = 0, seed_err = 0.
- Priority per edge: rst > load > en > hold.
- load with seed_in != 0: state <= seed_in.
- load with seed_in == 0: state <= SEED and seed_err = 1 for the next cycle only.
- load and en both high: the load wins and no step occurs in that cycle.
- Fibonacci step: fb = XOR-reduce(state & TAPS); state <= {state[WIDTH-2:0], fb}.
- Galois step: fb = state[WIDTH-1]; state <= {state[WIDTH-2:0], 1'b0} ^ (fb ? TAPS : 0).
  - TAPS[0] must be 1 in Galois mode.
- en low: state holds.
- Latency: out reflects a load or step one cycle after the qualifying edge; out and bit_out are registered-state outputs with no combinational input-to-output path.
- lockup = (state == 0); combinational from the state register.
  - All-zero is reachable only through illegal parameters or an upset. The block does not self-recover.
  - Recovery is by load or rst.
- rst asserted at any time, including mid-sequence or together with load: state = SEED on the next edge.
- Elaboration checks: SEED == 0, TAPS[WIDTH-1] == 0, or MODE == 1 with TAPS[0] == 0 raise $error.

Optional Feature:
LFSR_PERIOD_CNT_EN
- Defined:
  - Adds a start-value register, captured on reset and on every accepted load.
  - Adds a WIDTH-bit step counter, cleared on reset/load and incremented on each en step.
  - Adds output period_done (1 bit): one-cycle pulse when a step returns state to the start value.
  - Adds output period (WIDTH bits): registered step count latched at that moment; reset value 0.
  - The counter restarts from 1 after each wrap.
- Undefined: these ports and registers are absent; core behaviour is unchanged.

Decomposition:
- Package lfsr_pkg holds:
  - MODE_FIBONACCI = 0 and MODE_GALOIS = 1 constants.
  - A function next_state(state, taps, mode), shared by RTL and the bench reference model.
  - Common maximal tap constants: W4 = 4'h9, W8 = 8'hB8, W16 = 16'hB400.
- Optional sub-module lfsr_period_mon contains the period counter and start register, instantiated only under LFSR_PERIOD_CNT_EN. The core stays a single module.

Test Plan:
1. WIDTH=4, TAPS=4'h9, SEED=4'hE, Fibonacci; release rst, en=1 -> out = E, D, A, 5, ...; returns to E after exactly 15 steps with no repeat in between.
2. WIDTH=4, TAPS=4'h3, Galois; load seed_in=4'h1, then en=1 -> out = 1, 2, 4, 8, 3, ...; period 15.
3. load seed_in=0 -> out = SEED next cycle; seed_err high exactly one cycle; lockup stays 0.
4. en toggled 1,0,0,1 -> state advances only on en-high edges; load and en together -> out = seed_in, no extra step.
5. Force state 0 via hierarchical deposit -> lockup = 1 and state stays 0 with en=1; load 4'h7 -> lockup drops the next cycle.
6. With LFSR_PERIOD_CNT_EN, WIDTH=8, TAPS=8'hB8 -> period_done pulses after 255 steps with period = 255; rst mid-run -> counter and period clear to 0.

Source files
------------

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared constants and single-step function for the LFSR generator family.
`default_nettype none

package lfsr_pkg;

  localparam int MODE_FIBONACCI = 0;
  localparam int MODE_GALOIS    = 1;

  // Maximal-length tap masks for common widths
  localparam logic [3:0]  W4  = 4'h9;
  localparam logic [7:0]  W8  = 8'hB8;
  localparam logic [15:0] W16 = 16'hB400;

  // One LFSR step on a right-aligned state of the given width (1..32).
  function automatic logic [31:0] next_state(input logic [31:0] state,
                                             input logic [31:0] taps,
                                             input logic        mode,
                                             input int unsigned width);
    logic [31:0] mask;
    logic [31:0] s;
    logic [31:0] result;
    logic        fb;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    s    = state & mask;
    if (!mode) begin
      fb     = ^(s & taps);
      result = ((s << 1) | {31'd0, fb}) & mask;
    end else begin
      fb     = |(s & (32'd1 << (width - 1)));
      result = ((s << 1) & mask) ^ (fb ? (taps & mask) : 32'd0);
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_period_mon.sv
// lfsr_period_mon: counts steps until the state returns to the last start value.
`default_nettype none

module lfsr_period_mon #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  input  logic [WIDTH-1:0] next_val,
  output logic             period_done,
  output logic [WIDTH-1:0] period
);

  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      start       <= SEED;
      count       <= '0;
      period      <= '0;
      period_done <= 1'b0;
    end else begin
      period_done <= 1'b0;
      if (load) begin
        start <= load_val;
        count <= '0;
      end else if (step) begin
        // Wrap: the step that lands back on start closes the period
        if (next_val == start) begin
          period      <= count + WIDTH'(1);
          period_done <= 1'b1;
          count       <= '0;
        end else begin
          count <= count + WIDTH'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci/Galois LFSR with seed load, lockup flag and zero-seed guard.
// Optional period monitor when LFSR_PERIOD_CNT_EN is defined.
`default_nettype none

module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01,
  parameter int               MODE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] out,
  output logic             bit_out,
  output logic             lockup,
  output logic             seed_err
`ifdef LFSR_PERIOD_CNT_EN
  ,
  output logic             period_done,
  output logic [WIDTH-1:0] period
`endif
);

  if (SEED == '0) begin : g_chk_seed
    $error("lfsr_gen: SEED must be non-zero");
  end
  if (!TAPS[WIDTH-1]) begin : g_chk_msb
    $error("lfsr_gen: TAPS[WIDTH-1] must be set");
  end
  if (MODE == MODE_GALOIS && !TAPS[0]) begin : g_chk_galois
    $error("lfsr_gen: Galois mode requires TAPS[0] set");
  end

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_val;

  assign step_val = WIDTH'(next_state(32'(state), 32'(TAPS), MODE == MODE_GALOIS, WIDTH));
  // A zero seed would lock the register, so it falls back to SEED
  assign load_val = (seed_in != '0) ? seed_in : SEED;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SEED;
      seed_err <= 1'b0;
    end else begin
      seed_err <= 1'b0;
      if (load) begin
        state    <= load_val;
        seed_err <= (seed_in == '0);
      end else if (en) begin
        state <= step_val;
      end
    end
  end

  assign out     = state;
  assign bit_out = state[WIDTH-1];
  assign lockup  = (state == '0);

`ifdef LFSR_PERIOD_CNT_EN
  lfsr_period_mon #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_period_mon (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_val    (load_val),
    .step        (en & ~load),
    .next_val    (step_val),
    .period_done (period_done),
    .period      (period)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: randomized self-checking bench for lfsr_gen against an arithmetic reference model.
`default_nettype none

module tb_lfsr_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Fibonacci W4, seed E
  logic       en_f = 0, load_f = 0;
  logic [3:0] seed_f = 0, out_f;
  logic       bit_f, lock_f, err_f;
  // Galois W4, taps 3
  logic       en_g = 0, load_g = 0;
  logic [3:0] seed_g = 0, out_g;
  logic       bit_g, lock_g, err_g;
  // Fibonacci W8 defaults
  logic       en_8 = 0, load_8 = 0;
  logic [7:0] seed_8 = 0, out_8;
  logic       bit_8, lock_8, err_8;
`ifdef LFSR_PERIOD_CNT_EN
  logic       pd_f, pd_g, pd_8;
  logic [3:0] per_f, per_g;
  logic [7:0] per_8;
`endif

  lfsr_gen #(.WIDTH(4), .TAPS(4'h9), .SEED(4'hE), .MODE(0)) dut_fib (
    .clk(clk), .rst(rst), .en(en_f), .load(load_f), .seed_in(seed_f),
    .out(out_f), .bit_out(bit_f), .lockup(lock_f), .seed_err(err_f)
`ifdef LFSR_PERIOD_CNT_EN
    , .period_done(pd_f), .period(per_f)
`endif
  );

  lfsr_gen #(.WIDTH(4), .TAPS(4'h3), .SEED(4'h1), .MODE(1)) dut_gal (
    .clk(clk), .rst(rst), .en(en_g), .load(load_g), .seed_in(seed_g),
    .out(out_g), .bit_out(bit_g), .lockup(lock_g), .seed_err(err_g)
`ifdef LFSR_PERIOD_CNT_EN
    , .period_done(pd_g), .period(per_g)
`endif
  );

  lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .MODE(0)) dut_8 (
    .clk(clk), .rst(rst), .en(en_8), .load(load_8), .seed_in(seed_8),
    .out(out_8), .bit_out(bit_8), .lockup(lock_8), .seed_err(err_8)
`ifdef LFSR_PERIOD_CNT_EN
    , .period_done(pd_8), .period(per_8)
`endif
  );

  // Reference: shift left by doubling, feedback from tap parity or msb carry-out
  function automatic int ref_fib(int s, int taps, int w);
    int p = 0;
    for (int i = 0; i < w; i++)
      if (((s >> i) & 1) == 1 && ((taps >> i) & 1) == 1) p = 1 - p;
    return ((s * 2) % (1 << w)) + p;
  endfunction

  function automatic int ref_gal(int s, int taps, int w);
    int t = (s * 2) % (1 << w);
    if (s >= (1 << (w - 1))) t = t ^ taps;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (out_f !== 4'hE || lock_f !== 1'b0 || err_f !== 1'b0 || bit_f !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_fib: out=%h lock=%b err=%b bit=%b, need out=e lock=0 err=0 bit=1",
               out_f, lock_f, err_f, bit_f);
    end
    n_cmp++;
    if (out_g !== 4'h1 || out_8 !== 8'h01 || lock_8 !== 1'b0 || err_8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_other: gal=%h w8=%h lock8=%b err8=%b, need 1 01 0 0",
               out_g, out_8, lock_8, err_8);
    end
    rst = 1'b0;
  endtask

  task automatic test_fib_sequence();
    int exp_s = 14;
    bit seen[16];
    logic [3:0] first3 [3];
    first3[0] = 4'hD; first3[1] = 4'hA; first3[2] = 4'h5;
    foreach (seen[i]) seen[i] = 1'b0;
    seen[14] = 1'b1;
    en_f = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      exp_s = ref_fib(exp_s, 9, 4);
      n_cmp++;
      if (out_f !== 4'(exp_s) || bit_f !== out_f[3]) begin
        n_fail++;
        $display("FAIL fib_step%0d: out=%h bit=%b, need %h", i, out_f, bit_f, exp_s[3:0]);
      end
      if (i <= 3) begin
        n_cmp++;
        if (out_f !== first3[i-1]) begin
          n_fail++;
          $display("FAIL fib_const%0d: out=%h, need %h", i, out_f, first3[i-1]);
        end
      end
      if (i < 15) begin
        n_cmp++;
        if (seen[out_f]) begin
          n_fail++;
          $display("FAIL fib_repeat%0d: state %h repeated early", i, out_f);
        end
        seen[out_f] = 1'b1;
      end
    end
    n_cmp++;
    if (out_f !== 4'hE) begin
      n_fail++;
      $display("FAIL fib_period: out=%h after 15 steps, need e", out_f);
    end
    en_f = 1'b0;
  endtask

  task automatic test_galois();
    int exp_s = 1;
    logic [3:0] first5 [5];
    first5[0] = 4'h1; first5[1] = 4'h2; first5[2] = 4'h4; first5[3] = 4'h8; first5[4] = 4'h3;
    load_g = 1'b1; seed_g = 4'h1;
    tick();
    load_g = 1'b0;
    n_cmp++;
    if (out_g !== 4'h1) begin
      n_fail++;
      $display("FAIL gal_load: out=%h, need 1", out_g);
    end
    en_g = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      exp_s = ref_gal(exp_s, 3, 4);
      n_cmp++;
      if (out_g !== 4'(exp_s)) begin
        n_fail++;
        $display("FAIL gal_step%0d: out=%h, need %h", i, out_g, exp_s[3:0]);
      end
      if (i <= 4) begin
        n_cmp++;
        if (out_g !== first5[i]) begin
          n_fail++;
          $display("FAIL gal_const%0d: out=%h, need %h", i, out_g, first5[i]);
        end
      end
      if (i < 15) begin
        n_cmp++;
        if (out_g === 4'h1) begin
          n_fail++;
          $display("FAIL gal_early: returned to 1 after %0d steps, need 15", i);
        end
      end
    end
    n_cmp++;
    if (out_g !== 4'h1) begin
      n_fail++;
      $display("FAIL gal_period: out=%h after 15 steps, need 1", out_g);
    end
    en_g = 1'b0;
  endtask

  task automatic test_zero_seed();
    en_f = 1'b1;
    tick();
    tick();
    en_f = 1'b0; load_f = 1'b1; seed_f = 4'h0;
    tick();
    load_f = 1'b0;
    n_cmp++;
    if (out_f !== 4'hE || err_f !== 1'b1 || lock_f !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_seed: out=%h err=%b lock=%b, need e 1 0", out_f, err_f, lock_f);
    end
    tick();
    n_cmp++;
    if (err_f !== 1'b0 || out_f !== 4'hE || lock_f !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_seed_pulse: err=%b out=%h lock=%b, need 0 e 0", err_f, out_f, lock_f);
    end
  endtask

  task automatic test_enable();
    int exp_s = 14;
    logic pat [4];
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    for (int i = 0; i < 4; i++) begin
      en_f = pat[i];
      tick();
      if (pat[i]) exp_s = ref_fib(exp_s, 9, 4);
      n_cmp++;
      if (out_f !== 4'(exp_s)) begin
        n_fail++;
        $display("FAIL enable_pat%0d: out=%h, need %h", i, out_f, exp_s[3:0]);
      end
    end
    en_f = 1'b1; load_f = 1'b1; seed_f = 4'h6;
    tick();
    load_f = 1'b0; en_f = 1'b0;
    n_cmp++;
    if (out_f !== 4'h6 || err_f !== 1'b0) begin
      n_fail++;
      $display("FAIL load_over_en: out=%h err=%b, need 6 0", out_f, err_f);
    end
  endtask

  task automatic test_lockup();
    force dut_fib.state = 4'h0;
    #1;
    release dut_fib.state;
    #1;
    n_cmp++;
    if (lock_f !== 1'b1 || out_f !== 4'h0) begin
      n_fail++;
      $display("FAIL lockup_set: lock=%b out=%h, need 1 0", lock_f, out_f);
    end
    en_f = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (lock_f !== 1'b1 || out_f !== 4'h0) begin
      n_fail++;
      $display("FAIL lockup_hold: lock=%b out=%h, need 1 0", lock_f, out_f);
    end
    load_f = 1'b1; seed_f = 4'h7;
    tick();
    load_f = 1'b0; en_f = 1'b0;
    n_cmp++;
    if (lock_f !== 1'b0 || out_f !== 4'h7) begin
      n_fail++;
      $display("FAIL lockup_clear: lock=%b out=%h, need 0 7", lock_f, out_f);
    end
  endtask

  task automatic test_rst_priority();
    en_f = 1'b1; load_f = 1'b1; seed_f = 4'h3; rst = 1'b1;
    tick();
    rst = 1'b0; load_f = 1'b0; en_f = 1'b0;
    n_cmp++;
    if (out_f !== 4'hE || err_f !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_over_load: out=%h err=%b, need e 0", out_f, err_f);
    end
  endtask

  task automatic test_random();
    int m = 1;
    int s;
    bit exp_err;
    for (int i = 0; i < 300; i++) begin
      load_8 = ($urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
      seed_8 = 8'(s);
      en_8 = 1'($urandom_range(0, 1));
      tick();
      exp_err = 1'b0;
      if (load_8) begin
        m = (s != 0) ? s : 1;
        exp_err = (s == 0);
      end else if (en_8) begin
        m = ref_fib(m, 'hB8, 8);
      end
      n_cmp++;
      if (out_8 !== 8'(m) || bit_8 !== 1'(m >> 7) || err_8 !== exp_err || lock_8 !== 1'b0) begin
        n_fail++;
        $display("FAIL random%0d: out=%h bit=%b err=%b lock=%b, need %h %b %b 0",
                 i, out_8, bit_8, err_8, lock_8, m[7:0], 1'(m >> 7), exp_err);
      end
    end
    load_8 = 1'b0; en_8 = 1'b0;
  endtask

`ifdef LFSR_PERIOD_CNT_EN
  task automatic test_period();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en_8 = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      tick();
      n_cmp++;
      if (pd_8 !== (i == 255)) begin
        n_fail++;
        $display("FAIL period_done_step%0d: done=%b, need %b", i, pd_8, (i == 255));
      end
    end
    n_cmp++;
    if (per_8 !== 8'd255 || out_8 !== 8'h01) begin
      n_fail++;
      $display("FAIL period_value: period=%0d out=%h, need 255 01", per_8, out_8);
    end
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; en_8 = 1'b0;
    n_cmp++;
    if (per_8 !== 8'd0 || pd_8 !== 1'b0) begin
      n_fail++;
      $display("FAIL period_rst: period=%0d done=%b, need 0 0", per_8, pd_8);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fib_sequence();
    test_galois();
    test_zero_seed();
    test_enable();
    test_lockup();
    test_rst_priority();
    test_random();
`ifdef LFSR_PERIOD_CNT_EN
    test_period();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
